// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : State encodings and master IDs shared by the bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant; one-hot grant output.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On conflict the master that was not granted last wins
            2'b11:   grant = (last_grant == M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master to one-slave arbiter, one outstanding transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8,
    parameter int resp_width   = 1
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    m0_r_addr_valid,
    output logic                    m0_r_addr_ready,
    input  logic [addr_width-1:0]   m0_r_addr,
    output logic                    m0_r_data_valid,
    input  logic                    m0_r_data_ready,
    output logic [data_width-1:0]   m0_r_data,

    input  logic                    m1_r_addr_valid,
    output logic                    m1_r_addr_ready,
    input  logic [addr_width-1:0]   m1_r_addr,
    output logic                    m1_r_data_valid,
    input  logic                    m1_r_data_ready,
    output logic [data_width-1:0]   m1_r_data,
    input  logic                    m1_w_data_addr_valid,
    output logic                    m1_w_data_addr_ready,
    input  logic [data_width-1:0]   m1_w_data,
    input  logic [addr_width-1:0]   m1_w_addr,
    input  logic [strobe_width-1:0] m1_w_strobe,
    output logic                    m1_w_resp_valid,
    input  logic                    m1_w_resp_ready,
    output logic [resp_width-1:0]   m1_w_resp,

    output logic                    s_r_addr_valid,
    input  logic                    s_r_addr_ready,
    output logic [addr_width-1:0]   s_r_addr,
    input  logic                    s_r_data_valid,
    output logic                    s_r_data_ready,
    input  logic [data_width-1:0]   s_r_data,
    output logic                    s_w_data_addr_valid,
    input  logic                    s_w_data_addr_ready,
    output logic [data_width-1:0]   s_w_data,
    output logic [addr_width-1:0]   s_w_addr,
    output logic [strobe_width-1:0] s_w_strobe,
    input  logic                    s_w_resp_valid,
    output logic                    s_w_resp_ready,
    input  logic [resp_width-1:0]   s_w_resp
);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] req;
    logic [1:0] grant;

    assign req = {m1_r_addr_valid | m1_w_data_addr_valid, m0_r_addr_valid};

    rr_arbiter2 u_rr_arbiter2 (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Response payloads fan out unconditionally; only the valids are steered
    assign m0_r_data  = s_r_data;
    assign m1_r_data  = s_r_data;
    assign m1_w_resp  = s_w_resp;
    assign s_r_addr   = grant[1] ? m1_r_addr : m0_r_addr;
    assign s_w_data   = m1_w_data;
    assign s_w_addr   = m1_w_addr;
    assign s_w_strobe = m1_w_strobe;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= M0;
            last_grant_q <= M1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        owner_d              = owner_q;
        last_grant_d         = last_grant_q;
        m0_r_addr_ready      = 1'b0;
        m1_r_addr_ready      = 1'b0;
        m1_w_data_addr_ready = 1'b0;
        m0_r_data_valid      = 1'b0;
        m1_r_data_valid      = 1'b0;
        m1_w_resp_valid      = 1'b0;
        s_r_addr_valid       = 1'b0;
        s_w_data_addr_valid  = 1'b0;
        s_r_data_ready       = 1'b0;
        s_w_resp_ready       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    s_r_addr_valid  = 1'b1;
                    m0_r_addr_ready = s_r_addr_ready;
                    if (s_r_addr_ready) begin
                        state_d      = READ;
                        owner_d      = M0;
                        last_grant_d = M0;
                    end
                end else if (grant[1]) begin
                    // m1 read takes precedence over its own write
                    if (m1_r_addr_valid) begin
                        s_r_addr_valid  = 1'b1;
                        m1_r_addr_ready = s_r_addr_ready;
                        if (s_r_addr_ready) begin
                            state_d      = READ;
                            owner_d      = M1;
                            last_grant_d = M1;
                        end
                    end else begin
                        s_w_data_addr_valid  = 1'b1;
                        m1_w_data_addr_ready = s_w_data_addr_ready;
                        if (s_w_data_addr_ready) begin
                            state_d      = WRITE;
                            owner_d      = M1;
                            last_grant_d = M1;
                        end
                    end
                end
            end
            READ: begin
                if (owner_q == M0) begin
                    m0_r_data_valid = s_r_data_valid;
                    s_r_data_ready  = m0_r_data_ready;
                end else begin
                    m1_r_data_valid = s_r_data_valid;
                    s_r_data_ready  = m1_r_data_ready;
                end
                if (s_r_data_valid && s_r_data_ready) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                m1_w_resp_valid = s_w_resp_valid;
                s_w_resp_ready  = m1_w_resp_ready;
                if (s_w_resp_valid && m1_w_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshakes are suppressed outright while reset is held
        if (reset) begin
            m0_r_addr_ready      = 1'b0;
            m1_r_addr_ready      = 1'b0;
            m1_w_data_addr_ready = 1'b0;
            m0_r_data_valid      = 1'b0;
            m1_r_data_valid      = 1'b0;
            m1_w_resp_valid      = 1'b0;
            s_r_addr_valid       = 1'b0;
            s_w_data_addr_valid  = 1'b0;
            s_r_data_ready       = 1'b0;
            s_w_resp_ready       = 1'b0;
        end
    end

endmodule : bus_arbiter
`default_nettype wire
